cache_data_arbiter: RTL and testbench

Port arbiter and sequencer for the 4-way L1 D-cache data array. It shares the array's single read port between core loads and snoop data reads, and its single byte-masked write port between line fills and core stores. It returns read data to the winning requester with a fixed 1-cycle latency. It sits between the L1 controller / snoop unit / fill unit and the data array, inside each core's L1 slice.

---
 rtl/cache_data_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_data_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_arbiter.sv
// cache_data_arbiter: shares the L1 D-cache data array ports
// between core loads, snoop reads, line fills and core stores.
module cache_data_arbiter #(
  parameter int SETS         = 128,
  parameter int WAYS         = 4,
  parameter int LINE_BYTES   = 64,
  parameter int DATA_WIDTH   = LINE_BYTES*8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_rd_valid,
  output logic                      core_rd_ready,
  input  logic [$clog2(SETS)-1:0]   core_rd_set,
  input  logic [$clog2(WAYS)-1:0]   core_rd_way,
  output logic                      core_rd_rvalid,
  output logic [DATA_WIDTH-1:0]     core_rd_rdata,
  input  logic                      snp_rd_valid,
  output logic                      snp_rd_ready,
  input  logic [$clog2(SETS)-1:0]   snp_rd_set,
  input  logic [$clog2(WAYS)-1:0]   snp_rd_way,
  output logic                      snp_rd_rvalid,
  output logic [DATA_WIDTH-1:0]     snp_rd_rdata,
  input  logic                      fill_wr_valid,
  output logic                      fill_wr_ready,
  input  logic [$clog2(SETS)-1:0]   fill_wr_set,
  input  logic [$clog2(WAYS)-1:0]   fill_wr_way,
  input  logic [DATA_WIDTH-1:0]     fill_wr_data,
  input  logic [LINE_BYTES-1:0]     fill_wr_mask,
  input  logic                      core_wr_valid,
  output logic                      core_wr_ready,
  input  logic [$clog2(SETS)-1:0]   core_wr_set,
  input  logic [$clog2(WAYS)-1:0]   core_wr_way,
  input  logic [DATA_WIDTH-1:0]     core_wr_data,
  input  logic [LINE_BYTES-1:0]     core_wr_mask,
  output logic [$clog2(SETS)-1:0]   arr_read_set,
  output logic [$clog2(WAYS)-1:0]   arr_read_way,
  input  logic [DATA_WIDTH-1:0]     arr_read_data,
  output logic [$clog2(SETS)-1:0]   arr_write_set,
  output logic [$clog2(WAYS)-1:0]   arr_write_way,
  output logic [DATA_WIDTH-1:0]     arr_write_data,
  output logic [LINE_BYTES-1:0]     arr_write_mask,
  output logic                      busy
);

  localparam int CW = $clog2(STARVE_LIMIT+1);

  logic          r_rsp_core;
  logic          r_rsp_snp;
  logic          r_rr_snp;
  logic [CW-1:0] r_starve;

  logic w_crd_gnt;
  logic w_srd_gnt;
  logic w_fwr_gnt;
  logic w_cwr_gnt;
  logic w_cwr_pri;

  assign w_crd_gnt = rst_n & core_rd_valid
                   & (~snp_rd_valid | r_rr_snp);
  assign w_srd_gnt = rst_n & snp_rd_valid
                   & (~core_rd_valid | ~r_rr_snp);

  assign w_cwr_pri = (r_starve == CW'(STARVE_LIMIT));
  assign w_fwr_gnt = rst_n & fill_wr_valid
                   & ~(core_wr_valid & w_cwr_pri);
  assign w_cwr_gnt = rst_n & core_wr_valid
                   & (~fill_wr_valid | w_cwr_pri);

  assign core_rd_ready = w_crd_gnt;
  assign snp_rd_ready  = w_srd_gnt;
  assign fill_wr_ready = w_fwr_gnt;
  assign core_wr_ready = w_cwr_gnt;

  // read address follows the snoop only when it wins
  always_comb begin
    arr_read_set = core_rd_set;
    arr_read_way = core_rd_way;
    if (w_srd_gnt) begin
      arr_read_set = snp_rd_set;
      arr_read_way = snp_rd_way;
    end
  end

  // write port mux; mask forced to zero when nobody wins
  always_comb begin
    arr_write_set  = fill_wr_set;
    arr_write_way  = fill_wr_way;
    arr_write_data = fill_wr_data;
    arr_write_mask = '0;
    if (w_fwr_gnt) begin
      arr_write_mask = fill_wr_mask;
    end else if (w_cwr_gnt) begin
      arr_write_set  = core_wr_set;
      arr_write_way  = core_wr_way;
      arr_write_data = core_wr_data;
      arr_write_mask = core_wr_mask;
    end
  end

  // response tracking and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_core <= 1'b0;
      r_rsp_snp  <= 1'b0;
      r_rr_snp   <= 1'b1;
    end else begin
      r_rsp_core <= w_crd_gnt;
      r_rsp_snp  <= w_srd_gnt;
      if (w_crd_gnt)
        r_rr_snp <= 1'b0;
      else if (w_srd_gnt)
        r_rr_snp <= 1'b1;
    end
  end

  // count cycles a waiting core store loses to fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_cwr_gnt) begin
      r_starve <= '0;
    end else if (core_wr_valid && !w_cwr_pri) begin
      r_starve <= r_starve + CW'(1);
    end
  end

  assign core_rd_rvalid = r_rsp_core;
  assign snp_rd_rvalid  = r_rsp_snp;
  assign core_rd_rdata  = r_rsp_core ? arr_read_data : '0;
  assign snp_rd_rdata   = r_rsp_snp  ? arr_read_data : '0;

  assign busy = w_crd_gnt | w_srd_gnt | w_fwr_gnt | w_cwr_gnt
              | r_rsp_core | r_rsp_snp;

endmodule

// File: tb/tb_cache_data_arbiter.sv
// tb_cache_data_arbiter: scoreboard bench with an array model
// and a reference arbiter checked every falling edge.
module tb_cache_data_arbiter;

  logic clk;
  logic rst_n;
  logic         core_rd_valid, core_rd_ready;
  logic [6:0]   core_rd_set;
  logic [1:0]   core_rd_way;
  logic         core_rd_rvalid;
  logic [511:0] core_rd_rdata;
  logic         snp_rd_valid, snp_rd_ready;
  logic [6:0]   snp_rd_set;
  logic [1:0]   snp_rd_way;
  logic         snp_rd_rvalid;
  logic [511:0] snp_rd_rdata;
  logic         fill_wr_valid, fill_wr_ready;
  logic [6:0]   fill_wr_set;
  logic [1:0]   fill_wr_way;
  logic [511:0] fill_wr_data;
  logic [63:0]  fill_wr_mask;
  logic         core_wr_valid, core_wr_ready;
  logic [6:0]   core_wr_set;
  logic [1:0]   core_wr_way;
  logic [511:0] core_wr_data;
  logic [63:0]  core_wr_mask;
  logic [6:0]   arr_read_set;
  logic [1:0]   arr_read_way;
  logic [511:0] arr_read_data;
  logic [6:0]   arr_write_set;
  logic [1:0]   arr_write_way;
  logic [511:0] arr_write_data;
  logic [63:0]  arr_write_mask;
  logic         busy;

  int n_tot = 0;
  int n_bad = 0;

  logic [511:0] mem  [512];
  logic [511:0] gold [512];
  logic [511:0] qc[$];
  logic [511:0] qs[$];

  logic m_rr_snp;
  int   m_starve;
  logic m_g_crd, m_g_srd, m_g_fwr, m_g_cwr;

  cache_data_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_rd_valid(core_rd_valid), .core_rd_ready(core_rd_ready),
    .core_rd_set(core_rd_set), .core_rd_way(core_rd_way),
    .core_rd_rvalid(core_rd_rvalid), .core_rd_rdata(core_rd_rdata),
    .snp_rd_valid(snp_rd_valid), .snp_rd_ready(snp_rd_ready),
    .snp_rd_set(snp_rd_set), .snp_rd_way(snp_rd_way),
    .snp_rd_rvalid(snp_rd_rvalid), .snp_rd_rdata(snp_rd_rdata),
    .fill_wr_valid(fill_wr_valid), .fill_wr_ready(fill_wr_ready),
    .fill_wr_set(fill_wr_set), .fill_wr_way(fill_wr_way),
    .fill_wr_data(fill_wr_data), .fill_wr_mask(fill_wr_mask),
    .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
    .core_wr_set(core_wr_set), .core_wr_way(core_wr_way),
    .core_wr_data(core_wr_data), .core_wr_mask(core_wr_mask),
    .arr_read_set(arr_read_set), .arr_read_way(arr_read_way),
    .arr_read_data(arr_read_data),
    .arr_write_set(arr_write_set), .arr_write_way(arr_write_way),
    .arr_write_data(arr_write_data),
    .arr_write_mask(arr_write_mask),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] merge(input logic [511:0] o,
                                         input logic [511:0] d,
                                         input logic [63:0] m);
    logic [511:0] r;
    r = o;
    for (int b = 0; b < 64; b++)
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [511:0] line_init(input int idx);
    logic [7:0] v;
    v = (idx == 22) ? 8'hA5 : 8'(idx*37 + 11);
    return {64{v}};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int lidx(input logic [6:0] s,
                              input logic [1:0] w);
    return int'(s)*4 + int'(w);
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]  = line_init(i);
      gold[i] = line_init(i);
    end
    arr_read_data = '0;
  end

  // data array model: write-first, read data registered
  always @(posedge clk) begin
    int wi;
    int ri;
    wi = lidx(arr_write_set, arr_write_way);
    ri = lidx(arr_read_set, arr_read_way);
    if (arr_write_mask != 64'd0)
      mem[wi] = merge(mem[wi], arr_write_data, arr_write_mask);
    arr_read_data <= mem[ri];
  end

  // reference arbiter and response scoreboard
  always @(negedge clk) begin
    logic e_rsp;
    logic pri;
    logic [63:0] e_mask;
    logic [511:0] t;
    int wi;
    if (!rst_n) begin
      qc.delete();
      qs.delete();
      m_rr_snp = 1'b1;
      m_starve = 0;
      m_g_crd = 0; m_g_srd = 0; m_g_fwr = 0; m_g_cwr = 0;
      chk("rst_crv", core_rd_rvalid, 0);
      chk("rst_srv", snp_rd_rvalid, 0);
      chk("rst_rdy", {core_rd_ready, snp_rd_ready,
                      fill_wr_ready, core_wr_ready}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wmask", arr_write_mask, 0);
    end else begin
      e_rsp = (qc.size() != 0) || (qs.size() != 0);
      chk("c_rvalid", core_rd_rvalid, qc.size() != 0);
      if (qc.size() != 0) begin
        t = qc.pop_front();
        if (core_rd_rvalid) chk("c_rdata", core_rd_rdata, t);
      end
      chk("s_rvalid", snp_rd_rvalid, qs.size() != 0);
      if (qs.size() != 0) begin
        t = qs.pop_front();
        if (snp_rd_rvalid) chk("s_rdata", snp_rd_rdata, t);
      end
      m_g_crd = core_rd_valid && (!snp_rd_valid || m_rr_snp);
      m_g_srd = snp_rd_valid && (!core_rd_valid || !m_rr_snp);
      pri = (m_starve == 4);
      m_g_fwr = fill_wr_valid && !(core_wr_valid && pri);
      m_g_cwr = core_wr_valid && (!fill_wr_valid || pri);
      chk("crd_rdy", core_rd_ready, m_g_crd);
      chk("srd_rdy", snp_rd_ready, m_g_srd);
      chk("fwr_rdy", fill_wr_ready, m_g_fwr);
      chk("cwr_rdy", core_wr_ready, m_g_cwr);
      chk("busy", busy,
          m_g_crd || m_g_srd || m_g_fwr || m_g_cwr || e_rsp);
      e_mask = m_g_fwr ? fill_wr_mask :
               m_g_cwr ? core_wr_mask : 64'd0;
      chk("wmask", arr_write_mask, e_mask);
      if (m_g_fwr || m_g_cwr) begin
        wi = m_g_fwr ? lidx(fill_wr_set, fill_wr_way)
                     : lidx(core_wr_set, core_wr_way);
        chk("widx", lidx(arr_write_set, arr_write_way), wi);
        chk("wdata", arr_write_data,
            m_g_fwr ? fill_wr_data : core_wr_data);
        gold[wi] = merge(gold[wi],
                         m_g_fwr ? fill_wr_data : core_wr_data,
                         e_mask);
      end
      if (m_g_crd) qc.push_back(gold[lidx(core_rd_set, core_rd_way)]);
      if (m_g_srd) qs.push_back(gold[lidx(snp_rd_set, snp_rd_way)]);
      if (m_g_crd) m_rr_snp = 1'b0;
      else if (m_g_srd) m_rr_snp = 1'b1;
      if (m_g_cwr) m_starve = 0;
      else if (core_wr_valid && m_starve < 4) m_starve++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_rd_valid = 0;
    snp_rd_valid  = 0;
    fill_wr_valid = 0;
    core_wr_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  initial begin
    logic [511:0] exp;
    logic [511:0] wd;
    rst_n = 1;
    idle();
    core_rd_set = 0; core_rd_way = 0;
    snp_rd_set = 0;  snp_rd_way = 0;
    fill_wr_set = 0; fill_wr_way = 0;
    fill_wr_data = '0; fill_wr_mask = '0;
    core_wr_set = 0; core_wr_way = 0;
    core_wr_data = '0; core_wr_mask = '0;
    #2 rst_n = 0;
    core_rd_valid = 1;
    fill_wr_valid = 1;
    fill_wr_mask  = '1;
    repeat (3) cyc();
    chk("rst_rdy_hold", core_rd_ready, 0);
    idle();
    rst_n = 1;
    cyc();

    core_rd_valid = 1; core_rd_set = 5; core_rd_way = 2;
    #1 chk("rd1_rdy", core_rd_ready, 1);
    cyc();
    core_rd_valid = 0;
    #1 chk("rd1_rv", core_rd_rvalid, 1);
    chk("rd1_data", core_rd_rdata, {64{8'hA5}});
    chk("rd1_srv", snp_rd_rvalid, 0);
    cyc();

    do_reset();
    core_rd_valid = 1; core_rd_set = 1; core_rd_way = 0;
    snp_rd_valid  = 1; snp_rd_set  = 2; snp_rd_way  = 3;
    for (int i = 0; i < 4; i++) begin
      #1 chk("alt_c", core_rd_ready, (i % 2) == 0);
      chk("alt_s", snp_rd_ready, (i % 2) == 1);
      cyc();
    end
    idle();
    cyc();

    fill_wr_valid = 1; fill_wr_set = 10; fill_wr_way = 0;
    fill_wr_data = rnd512(); fill_wr_mask = '1;
    core_wr_valid = 1; core_wr_set = 10; core_wr_way = 1;
    core_wr_data = rnd512(); core_wr_mask = 64'hF0;
    for (int i = 0; i < 6; i++) begin
      #1 chk("stv_cw", core_wr_ready, i == 4);
      chk("stv_f", fill_wr_ready, i != 4);
      cyc();
    end
    idle();
    cyc();

    wd = '0; wd[7:0] = 8'h7E;
    fill_wr_valid = 1; fill_wr_set = 3; fill_wr_way = 1;
    fill_wr_data = wd; fill_wr_mask = 64'h1;
    #1 chk("fw_rdy", fill_wr_ready, 1);
    cyc();
    fill_wr_valid = 0;
    core_rd_valid = 1; core_rd_set = 3; core_rd_way = 1;
    cyc();
    core_rd_valid = 0;
    exp = line_init(13);
    exp[7:0] = 8'h7E;
    #1 chk("fw_rv", core_rd_rvalid, 1);
    chk("fw_data", core_rd_rdata, exp);
    cyc();

    wd = '0; wd[15:8] = 8'h11;
    core_rd_valid = 1; core_rd_set = 3; core_rd_way = 1;
    core_wr_valid = 1; core_wr_set = 3; core_wr_way = 1;
    core_wr_data = wd; core_wr_mask = 64'h2;
    #1 chk("co_rrdy", core_rd_ready, 1);
    chk("co_wrdy", core_wr_ready, 1);
    cyc();
    idle();
    exp[15:8] = 8'h11;
    #1 chk("co_data", core_rd_rdata, exp);
    cyc();

    fill_wr_valid = 1; fill_wr_set = 4; fill_wr_way = 2;
    fill_wr_data = rnd512(); fill_wr_mask = 64'd0;
    #1 chk("zm_rdy", fill_wr_ready, 1);
    chk("zm_mask", arr_write_mask, 0);
    cyc();
    idle();
    cyc();

    for (int n = 0; n < 300; n++) begin
      if (!core_rd_valid || m_g_crd) begin
        core_rd_valid = 1'($urandom_range(0, 1));
        core_rd_set = 7'($urandom_range(0, 3));
        core_rd_way = 2'($urandom_range(0, 3));
      end
      if (!snp_rd_valid || m_g_srd) begin
        snp_rd_valid = 1'($urandom_range(0, 1));
        snp_rd_set = 7'($urandom_range(0, 3));
        snp_rd_way = 2'($urandom_range(0, 3));
      end
      if (!fill_wr_valid || m_g_fwr) begin
        fill_wr_valid = ($urandom_range(0, 3) != 0);
        fill_wr_set = 7'($urandom_range(0, 3));
        fill_wr_way = 2'($urandom_range(0, 3));
        fill_wr_data = rnd512();
        fill_wr_mask = {$urandom, $urandom};
      end
      if (!core_wr_valid || m_g_cwr) begin
        core_wr_valid = 1'($urandom_range(0, 1));
        core_wr_set = 7'($urandom_range(0, 3));
        core_wr_way = 2'($urandom_range(0, 3));
        core_wr_data = rnd512();
        core_wr_mask = {$urandom, $urandom};
      end
      cyc();
    end
    idle();
    repeat (2) cyc();

    core_rd_valid = 1; core_rd_set = 0; core_rd_way = 0;
    cyc();
    core_rd_valid = 0;
    fill_wr_valid = 1; fill_wr_set = 6; fill_wr_way = 0;
    fill_wr_data = rnd512(); fill_wr_mask = '1;
    rst_n = 0;
    #1 chk("mr_rv", core_rd_rvalid, 0);
    cyc();
    fill_wr_valid = 0;
    rst_n = 1;
    #1 chk("mr_busy", busy, 0);
    chk("mr_rv2", core_rd_rvalid, 0);
    cyc();
    core_rd_valid = 1; core_rd_set = 6; core_rd_way = 0;
    snp_rd_valid  = 1; snp_rd_set  = 1; snp_rd_way  = 1;
    #1 chk("mr_rr", core_rd_ready, 1);
    cyc();
    idle();
    #1 chk("mr_nowr", core_rd_rdata, line_init(24));
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
